// File: rtl/expipe_pkg.sv
// Shared execution-pipeline types: EU count, CDB result payload and arbiter pointer width.
package expipe_pkg;

    localparam int unsigned EU_N           = 6;
    localparam int unsigned XLEN           = 32;
    localparam int unsigned ROB_IDX_LEN    = 4;
    localparam int unsigned EXCEPT_CODE_W  = 5;
    localparam int unsigned EU_LOAD_BUFFER = 0;

    localparam int unsigned CDB_PTR_W = $clog2(EU_N);

    typedef struct packed {
        logic [ROB_IDX_LEN-1:0]   rob_idx;
        logic [XLEN-1:0]          res_value;
        logic                     except_raised;
        logic [EXCEPT_CODE_W-1:0] except_code;
    } cdb_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned PtrW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [PtrW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [PtrW-1:0] idx
);

    int unsigned    cand;
    logic [PtrW-1:0] cand_idx;
    logic           found;

    always_comb begin
        gnt      = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = ptr + off;
            // N need not be a power of 2, so wrap explicitly
            if (cand >= N) cand = cand - N;
            cand_idx = PtrW'(cand);
            if (!found && req[cand_idx]) begin
                gnt[cand_idx] = 1'b1;
                idx           = cand_idx;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant among EUs into a single-entry output register.
// Optional LEN5_CDB_LOAD_PRIO_EN gives EU 0 (load buffer) absolute priority.
module cdb_arbiter
    import expipe_pkg::*;
#(
    parameter int unsigned N_EU = EU_N
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic [N_EU-1:0] valid_i,
    output logic [N_EU-1:0] ready_o,
    input  cdb_data_t       data_i [N_EU],
    output logic            cdb_valid_o,
    input  logic            cdb_ready_i,
    output cdb_data_t       cdb_data_o
);

    localparam int unsigned PtrW = $clog2(N_EU);

    logic            vld_q;
    cdb_data_t       data_q;
    logic [PtrW-1:0] ptr_q;

    logic [N_EU-1:0] rr_req;
    logic [N_EU-1:0] rr_gnt;
    logic [PtrW-1:0] rr_idx;
    logic [N_EU-1:0] gnt;
    logic [PtrW-1:0] g_idx;
    logic            ptr_upd;
    logic [PtrW-1:0] ptr_nxt;
    logic            load_en;
    logic            accept;
    logic            xfer;

`ifdef LEN5_CDB_LOAD_PRIO_EN
    assign rr_req  = {valid_i[N_EU-1:1], 1'b0};
    assign gnt     = valid_i[EU_LOAD_BUFFER] ? N_EU'(1) : rr_gnt;
    assign g_idx   = valid_i[EU_LOAD_BUFFER] ? PtrW'(EU_LOAD_BUFFER) : rr_idx;
    // load grants bypass the rotation, so they leave the pointer alone
    assign ptr_upd = !valid_i[EU_LOAD_BUFFER];
`else
    assign rr_req  = valid_i;
    assign gnt     = rr_gnt;
    assign g_idx   = rr_idx;
    assign ptr_upd = 1'b1;
`endif

    rr_arbiter #(
        .N    (N_EU),
        .PtrW (PtrW)
    ) u_rr_arbiter (
        .req (rr_req),
        .ptr (ptr_q),
        .gnt (rr_gnt),
        .idx (rr_idx)
    );

    assign load_en = !vld_q || cdb_ready_i;
    assign accept  = load_en && !flush_i && rst_n_i;
    assign ready_o = accept ? gnt : '0;
    assign xfer    = |ready_o;
    assign ptr_nxt = (g_idx == PtrW'(N_EU - 1)) ? '0 : g_idx + PtrW'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            vld_q  <= 1'b0;
            ptr_q  <= '0;
            data_q <= '0;
        end else if (flush_i) begin
            vld_q <= 1'b0;
        end else if (xfer) begin
            vld_q  <= 1'b1;
            data_q <= data_i[g_idx];
            if (ptr_upd) ptr_q <= ptr_nxt;
        end else if (cdb_ready_i) begin
            vld_q <= 1'b0;
        end
    end

    assign cdb_valid_o = vld_q;
    assign cdb_data_o  = data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (N_EU = 6, default build).
module tb_cdb_arbiter;
    import expipe_pkg::*;

    localparam int unsigned N = 6;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic [N-1:0] valid;
    logic [N-1:0] ready;
    cdb_data_t    data [N];
    logic         cdb_valid;
    logic         cdb_ready;
    cdb_data_t    cdb_data;

    int n_checks;
    int n_fail;

    cdb_arbiter #(
        .N_EU (N)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .flush_i     (flush),
        .valid_i     (valid),
        .ready_o     (ready),
        .data_i      (data),
        .cdb_valid_o (cdb_valid),
        .cdb_ready_i (cdb_ready),
        .cdb_data_o  (cdb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; #1 later outputs are settled and sampled.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        cdb_ready = 1'b1;
        valid     = 6'b111111;
        for (int i = 0; i < N; i++) begin
            data[i].rob_idx       = ROB_IDX_LEN'(i);
            data[i].res_value     = XLEN'(100 + i);
            data[i].except_raised = 1'b0;
            data[i].except_code   = '0;
        end

        // Reset held with all requesters active
        next_cycle(); #1;
        chk("rst_ready", 64'(ready), 64'h0);
        next_cycle(); next_cycle(); #1;
        chk("rst_ready2", 64'(ready), 64'h0);
        chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
        chk("rst_cdb_data", 64'(cdb_data), 64'h0);

        // Release: EU0 granted first
        rst_n = 1'b1; #1;
        chk("rel_ready", 64'(ready), 64'b000001);

        // Round-robin wrap between EU5 and EU0
        next_cycle();
        valid = 6'b100001; #1;
        chk("rr_valid0", 64'(cdb_valid), 64'h1);
        chk("rr_rob0", 64'(cdb_data.rob_idx), 64'd0);
        for (int k = 0; k < 4; k++) begin
            chk("rr_ready", 64'(ready), (k % 2 == 0) ? 64'b100000 : 64'b000001);
            next_cycle(); #1;
            chk("rr_rob", 64'(cdb_data.rob_idx), (k % 2 == 0) ? 64'd5 : 64'd0);
        end
        // ptr now 1

        // Backpressure: EU2 with rob_idx 3
        data[2].rob_idx = 4'd3;
        valid = 6'b000100; #1;
        chk("bp_grant", 64'(ready), 64'b000100);
        next_cycle();
        cdb_ready = 1'b0;
        data[2].res_value = 32'd150; #1;
        chk("bp_first_rob", 64'(cdb_data.rob_idx), 64'd3);
        for (int k = 0; k < 4; k++) begin
            chk("bp_ready", 64'(ready), 64'h0);
            chk("bp_rob", 64'(cdb_data.rob_idx), 64'd3);
            chk("bp_hold_val", 64'(cdb_data.res_value), 64'd102);
            chk("bp_vld", 64'(cdb_valid), 64'h1);
            next_cycle(); #1;
        end
        cdb_ready = 1'b1; #1;
        chk("bp_regrant", 64'(ready), 64'b000100);
        next_cycle(); #1;
        chk("bp_refill_val", 64'(cdb_data.res_value), 64'd150);
        chk("bp_refill_vld", 64'(cdb_valid), 64'h1);
        // ptr now 3

        // Flush with a buffered result; a grant here would move ptr to 5
        flush = 1'b1;
        cdb_ready = 1'b0;
        valid = 6'b010100; #1;
        chk("fl_ready", 64'(ready), 64'h0);
        next_cycle();
        flush = 1'b0;
        cdb_ready = 1'b1;
        valid = 6'b111111; #1;
        chk("fl_vld", 64'(cdb_valid), 64'h0);
        chk("fl_ptr_kept", 64'(ready), 64'b001000);
        next_cycle();
        valid = 6'b000000; #1;
        chk("fl_after_rob", 64'(cdb_data.rob_idx), 64'd3);
        chk("fl_after_vld", 64'(cdb_valid), 64'h1);
        // ptr now 4

        // Idle: drain then nothing
        chk("idle_ready", 64'(ready), 64'h0);
        next_cycle(); #1;
        chk("idle_drain", 64'(cdb_valid), 64'h0);
        next_cycle(); #1;
        chk("idle_vld", 64'(cdb_valid), 64'h0);
        valid = 6'b111111; #1;
        chk("idle_ptr_kept", 64'(ready), 64'b010000);
        next_cycle(); #1;
        chk("idle_refill_rob", 64'(cdb_data.rob_idx), 64'd4);
        chk("idle_refill_vld", 64'(cdb_valid), 64'h1);

        // Mid-operation reset drops the buffered result
        rst_n = 1'b0; #1;
        chk("mrst_ready", 64'(ready), 64'h0);
        next_cycle(); #1;
        chk("mrst_vld", 64'(cdb_valid), 64'h0);
        rst_n = 1'b1; #1;
        chk("mrst_ptr", 64'(ready), 64'b000001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
